clause_bin_loader: RTL

- Controller directly upstream of clause_array. Moves one bin of clauses between bin clause memory and the clause array.
- LOAD: reads clauses from memory and writes one clause per cycle into array slots via one-hot wr.
- UPDATE: reads array slots back via one-hot rd (slot contents include assignments changed during solving) and writes them to memory.
- Keeps a per-slot length store so memory write-back carries the original clause length.

---
 rtl/clause_bin_loader_pkg.sv | 41 ++++
 rtl/clause_bin_loader_len.sv | 43 ++++
 rtl/clause_bin_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clause_bin_loader_pkg.sv
// ---------------------------------------------------------------------------
// clause_bin_loader_pkg
//   Shared constants, the controller state type and a one-hot helper for the
//   clause bin loader and its length store.
//
//   Contents:
//     CBL_*            default sizing of the clause array / bin memory
//     WIDTH_CLAUSE     clause word width (two bits per variable)
//     WIDTH_MEM_WORD   bin memory word width, {len, clause}
//     cbl_state_e      controller state encoding
//     onehot_from_index  index -> one-hot vector (MAX_SLOTS wide)
// ---------------------------------------------------------------------------
package clause_bin_loader_pkg;

    localparam int CBL_NUM_CLAUSES = 8;
    localparam int CBL_NUM_VARS    = 8;
    localparam int CBL_WIDTH_C_LEN = 4;
    localparam int CBL_WIDTH_ADDR  = 10;

    localparam int WIDTH_CLAUSE   = CBL_NUM_VARS * 2;
    localparam int WIDTH_MEM_WORD = CBL_WIDTH_C_LEN + WIDTH_CLAUSE;

    // Upper bound on the one-hot width the helper can produce; callers slice
    // the low NUM_CLAUSES bits.
    localparam int MAX_SLOTS = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_LOAD_TAIL = 3'd2,
        ST_UPDATE    = 3'd3,
        ST_DONE      = 3'd4
    } cbl_state_e;

    function automatic logic [MAX_SLOTS-1:0] onehot_from_index(input int unsigned idx);
        logic [MAX_SLOTS-1:0] v;
        v = {{(MAX_SLOTS-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/clause_bin_loader_len.sv
// ---------------------------------------------------------------------------
// clause_len_store
//   Per-slot clause length register file. Written while a bin is loaded into
//   the clause array and read back when the slots are written to memory, so
//   the write-back word carries the length the clause was loaded with.
//
//   Ports:
//     clk, rst   clock, synchronous active-high reset (clears all lengths)
//     wr_en      write strobe
//     wr_idx     slot index to write
//     wr_len     length value to store
//     rd_idx     slot index to read
//     rd_len     stored length of rd_idx (combinational)
// ---------------------------------------------------------------------------
module clause_len_store #(
    parameter int NUM_CLAUSES = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int SLOT_W      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [SLOT_W-1:0]      wr_idx,
    input  logic [WIDTH_C_LEN-1:0] wr_len,
    input  logic [SLOT_W-1:0]      rd_idx,
    output logic [WIDTH_C_LEN-1:0] rd_len
);

    logic [WIDTH_C_LEN-1:0] len_q [NUM_CLAUSES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLAUSES; i++) begin
                len_q[i] <= '0;
            end
        end else if (wr_en) begin
            len_q[wr_idx] <= wr_len;
        end
    end

    assign rd_len = len_q[rd_idx];

endmodule

// File: rtl/clause_bin_loader.sv
// ---------------------------------------------------------------------------
// clause_bin_loader
//   Moves one bin of clauses between the bin clause memory and the clause
//   array.
//     LOAD   : reads cnt clauses from memory (base, base+1, ...) and writes
//              every array slot once, one slot per cycle; slots at or above
//              cnt are cleared to clause 0 / length 0.
//     UPDATE : reads every array slot once; the first cnt slots are written
//              back to memory as {stored length, current clause}.
//   cnt = min(clause_cnt_i, NUM_CLAUSES), latched with base at start.
//
//   Handshake: a start is only seen in IDLE; start_load_i has priority over
//   start_update_i. busy_o covers the working cycles, done_o pulses for one
//   cycle afterwards. Memory reads return data exactly one cycle after the
//   mem_rd_en_o strobe; the array read data ca_clause_i is valid in the same
//   cycle as ca_rd_o.
//
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     start_load_i       request LOAD
//     start_update_i     request UPDATE
//     base_addr_i        memory address of the slot 0 clause
//     clause_cnt_i       number of valid clauses in the bin
//     busy_o, done_o     operation status
//     mem_rd_en_o        memory read strobe
//     mem_addr_o         memory address (read or write)
//     mem_rdata_i        memory read data {len, clause}
//     mem_wr_en_o        memory write strobe
//     mem_wdata_o        memory write data {len, clause}
//     ca_wr_o, ca_rd_o   one-hot clause array slot write / read
//     ca_clause_o        clause word to the array
//     ca_clause_len_o    clause length to the array
//     ca_clause_i        clause word from the array
//     dbg_state          current controller state
// ---------------------------------------------------------------------------
module clause_bin_loader
    import clause_bin_loader_pkg::*;
#(
    parameter int NUM_CLAUSES = CBL_NUM_CLAUSES,
    parameter int NUM_VARS    = CBL_NUM_VARS,
    parameter int WIDTH_C_LEN = CBL_WIDTH_C_LEN,
    parameter int WIDTH_ADDR  = CBL_WIDTH_ADDR
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_load_i,
    input  logic                              start_update_i,
    input  logic [WIDTH_ADDR-1:0]             base_addr_i,
    input  logic [WIDTH_C_LEN-1:0]            clause_cnt_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              mem_rd_en_o,
    output logic [WIDTH_ADDR-1:0]             mem_addr_o,
    input  logic [WIDTH_C_LEN+NUM_VARS*2-1:0] mem_rdata_i,
    output logic                              mem_wr_en_o,
    output logic [WIDTH_C_LEN+NUM_VARS*2-1:0] mem_wdata_o,
    output logic [NUM_CLAUSES-1:0]            ca_wr_o,
    output logic [NUM_CLAUSES-1:0]            ca_rd_o,
    output logic [NUM_VARS*2-1:0]             ca_clause_o,
    output logic [WIDTH_C_LEN-1:0]            ca_clause_len_o,
    input  logic [NUM_VARS*2-1:0]             ca_clause_i,
    output cbl_state_e                        dbg_state
);

    localparam int CLW    = NUM_VARS * 2;
    localparam int MWW    = WIDTH_C_LEN + CLW;
    // Wide enough to hold NUM_CLAUSES itself (the clamped count and the
    // index one past the last slot).
    localparam int CNT_W  = $clog2(NUM_CLAUSES + 1);
    localparam int SLOT_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CLAUSES - 1);

    function automatic logic [NUM_CLAUSES-1:0] slot_oh(input logic [CNT_W-1:0] i);
        logic [MAX_SLOTS-1:0] full;
        full = onehot_from_index(32'(i));
        return full[NUM_CLAUSES-1:0];
    endfunction

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    cbl_state_e              state_q;
    logic [CNT_W-1:0]        idx_q;       // slot index j of the current cycle
    logic [CNT_W-1:0]        cnt_q;
    logic [WIDTH_ADDR-1:0]   base_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rd_en_q;
    logic                    wr_en_q;
    logic [WIDTH_ADDR-1:0]   addr_q;
    logic [NUM_CLAUSES-1:0]  ca_wr_q;
    logic [NUM_CLAUSES-1:0]  ca_rd_q;
    logic [SLOT_W-1:0]       wr_slot_q;   // slot written this cycle in LOAD
    logic                    wr_from_mem_q; // slot write uses returned memory data

    logic [CNT_W-1:0]        cnt_clamp;
    logic [CNT_W-1:0]        idx_nxt;
    logic                    nxt_valid;

    always_comb begin
        cnt_clamp = CNT_W'(NUM_CLAUSES);
        if (int'(clause_cnt_i) < NUM_CLAUSES) begin
            cnt_clamp = CNT_W'(clause_cnt_i);
        end
    end

    assign idx_nxt   = idx_q + CNT_W'(1);
    assign nxt_valid = (idx_nxt < cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            base_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            addr_q        <= '0;
            ca_wr_q       <= '0;
            ca_rd_q       <= '0;
            wr_slot_q     <= '0;
            wr_from_mem_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rd_en_q       <= 1'b0;
                    wr_en_q       <= 1'b0;
                    addr_q        <= '0;
                    ca_wr_q       <= '0;
                    ca_rd_q       <= '0;
                    wr_from_mem_q <= 1'b0;
                    if (start_load_i) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                        base_q  <= base_addr_i;
                        cnt_q   <= cnt_clamp;
                        idx_q   <= '0;
                        // Slot 0 read is issued in the first LOAD cycle.
                        rd_en_q <= (cnt_clamp != '0);
                        addr_q  <= (cnt_clamp != '0) ? base_addr_i : '0;
                    end else if (start_update_i) begin
                        state_q <= ST_UPDATE;
                        busy_q  <= 1'b1;
                        base_q  <= base_addr_i;
                        cnt_q   <= cnt_clamp;
                        idx_q   <= '0;
                        ca_rd_q <= slot_oh('0);
                        wr_en_q <= (cnt_clamp != '0);
                        addr_q  <= (cnt_clamp != '0) ? base_addr_i : '0;
                    end
                end

                ST_LOAD: begin
                    // Data for slot j arrives one cycle after its read, so
                    // the array write of slot j trails the read by a cycle.
                    ca_wr_q       <= slot_oh(idx_q);
                    wr_slot_q     <= idx_q[SLOT_W-1:0];
                    wr_from_mem_q <= (idx_q < cnt_q);
                    idx_q         <= idx_nxt;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_LOAD_TAIL;
                        rd_en_q <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        rd_en_q <= nxt_valid;
                        addr_q  <= nxt_valid ? base_q + WIDTH_ADDR'(idx_nxt) : '0;
                    end
                end

                ST_LOAD_TAIL: begin
                    // Last slot write happens in this cycle.
                    ca_wr_q       <= '0;
                    wr_from_mem_q <= 1'b0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b1;
                    state_q       <= ST_DONE;
                end

                ST_UPDATE: begin
                    idx_q <= idx_nxt;
                    if (idx_q == LAST_IDX) begin
                        ca_rd_q <= '0;
                        wr_en_q <= 1'b0;
                        addr_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        ca_rd_q <= slot_oh(idx_nxt);
                        wr_en_q <= nxt_valid;
                        addr_q  <= nxt_valid ? base_q + WIDTH_ADDR'(idx_nxt) : '0;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Length store
    // ---------------------------------------------------------------------
    logic [WIDTH_C_LEN-1:0] stored_len;
    logic                   slot_write;

    assign slot_write = |ca_wr_q;

    clause_len_store #(
        .NUM_CLAUSES (NUM_CLAUSES),
        .WIDTH_C_LEN (WIDTH_C_LEN),
        .SLOT_W      (SLOT_W)
    ) u_len_store (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (slot_write),
        .wr_idx (wr_slot_q),
        .wr_len (ca_clause_len_o),
        .rd_idx (idx_q[SLOT_W-1:0]),
        .rd_len (stored_len)
    );

    // ---------------------------------------------------------------------
    // Output data paths. These pass the returned memory word / array word
    // through in the same cycle; gating by the registered strobes keeps them
    // at zero whenever no transfer is in progress.
    // ---------------------------------------------------------------------
    assign ca_clause_o     = (slot_write && wr_from_mem_q) ? mem_rdata_i[CLW-1:0] : '0;
    assign ca_clause_len_o = (slot_write && wr_from_mem_q) ? mem_rdata_i[MWW-1:CLW] : '0;
    assign mem_wdata_o     = wr_en_q ? {stored_len, ca_clause_i} : '0;

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_rd_en_o = rd_en_q;
    assign mem_wr_en_o = wr_en_q;
    assign mem_addr_o  = addr_q;
    assign ca_wr_o     = ca_wr_q;
    assign ca_rd_o     = ca_rd_q;
    assign dbg_state   = state_q;

endmodule
